// File: rtl/pll_reconfig_pkg.sv
// Shared types and DRP bus bit positions for the PLL reconfiguration block.
package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ON,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_NEXT,
    ST_RST_OFF,
    ST_LOCK_WAIT
  } state_e;

  // reconfig_to_pll fields
  localparam int unsigned DI_LSB    = 0;
  localparam int unsigned DI_MSB    = 15;
  localparam int unsigned DADDR_LSB = 16;
  localparam int unsigned DADDR_MSB = 22;
  localparam int unsigned DEN_BIT   = 23;
  localparam int unsigned DWE_BIT   = 24;
  localparam int unsigned RST_BIT   = 25;
  localparam int unsigned DCLK_BIT  = 26;

  // reconfig_from_pll fields
  localparam int unsigned DO_LSB     = 0;
  localparam int unsigned DO_MSB     = 15;
  localparam int unsigned DRDY_BIT   = 16;
  localparam int unsigned LOCKED_BIT = 17;

  // One read-modify-write table entry (39 bits)
  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } entry_t;

  // Mask bit = 1 keeps the current register bit, 0 takes the new data bit
  function automatic logic [15:0] merge_bits(input logic [15:0] cur,
                                             input logic [15:0] mask,
                                             input logic [15:0] data);
    return (cur & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_reconfig_drp_if.sv
// Configuration, control/status and DRP bus signals of pll_reconfig_drp.
interface pll_reconfig_drp_if;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask;
  logic [15:0] cfg_data;
  logic [3:0]  cfg_count;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [63:0] reconfig_to_pll;
  logic [63:0] reconfig_from_pll;

  modport master (
    output cfg_we, cfg_idx, cfg_addr, cfg_mask, cfg_data, cfg_count, start,
    output reconfig_from_pll,
    input  busy, done, error, reconfig_to_pll
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_addr, cfg_mask, cfg_data, cfg_count, start,
    input  reconfig_from_pll,
    output busy, done, error, reconfig_to_pll
  );
endinterface

// File: rtl/pll_reconfig_table.sv
// Register file of read-modify-write entries: one write port, one async read port.
module pll_reconfig_table
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [2:0] widx_i,
  input  entry_t     wentry_i,
  input  logic [2:0] ridx_i,
  output entry_t     rentry_o
);

  entry_t mem_q [NUM_REGS];

  // Entry storage, cleared on reset; out-of-range writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(widx_i) < NUM_REGS)) begin
      mem_q[widx_i] <= wentry_i;
    end
  end

  assign rentry_o = (32'(ridx_i) < NUM_REGS) ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/pll_reconfig_drp.sv
// MMCM/PLL DRP reconfiguration sequencer: holds the MMCM in reset, applies
// read-modify-write entries over DRP, releases reset and waits for lock.
module pll_reconfig_drp
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input logic               clk,
  input logic               rst,
  pll_reconfig_drp_if.slave bus
);

  localparam int unsigned DTW       = $clog2(DRDY_TIMEOUT + 1);
  localparam int unsigned LTW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [3:0]  MAX_COUNT = 4'(NUM_REGS);

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      count_q, count_d;
  logic [15:0]     do_q, do_d;
  logic [DTW-1:0]  drdy_tmr_q, drdy_tmr_d;
  logic [LTW-1:0]  lock_tmr_q, lock_tmr_d;
  logic            error_q, error_d;
  logic            done_q, done_d;

  entry_t          wentry;
  entry_t          cur_entry;
  logic            tbl_we;
  logic            drdy;
  logic            locked;
  logic [15:0]     drp_do;
  logic            den;
  logic            dwe;
  logic            mmcm_rst;
  logic [63:0]     pll_out;
  logic            unused_from_pll;

  assign drp_do          = bus.reconfig_from_pll[DO_MSB:DO_LSB];
  assign drdy            = bus.reconfig_from_pll[DRDY_BIT];
  assign locked          = bus.reconfig_from_pll[LOCKED_BIT];
  assign unused_from_pll = ^bus.reconfig_from_pll[63:18];

  // Table writes only land while idle, so an entry can never change mid-sequence
  assign tbl_we = bus.cfg_we && (state_q == ST_IDLE);
  assign wentry = '{addr: bus.cfg_addr, mask: bus.cfg_mask, data: bus.cfg_data};

  pll_reconfig_table #(
    .NUM_REGS (NUM_REGS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (tbl_we),
    .widx_i   (bus.cfg_idx),
    .wentry_i (wentry),
    .ridx_i   (idx_q[2:0]),
    .rentry_o (cur_entry)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      do_q       <= '0;
      drdy_tmr_q <= '0;
      lock_tmr_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      do_q       <= do_d;
      drdy_tmr_q <= drdy_tmr_d;
      lock_tmr_q <= lock_tmr_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic, DRDY/lock timers and sticky error
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    do_d       = do_q;
    drdy_tmr_d = drdy_tmr_q;
    lock_tmr_d = lock_tmr_q;
    error_d    = error_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = (bus.cfg_count > MAX_COUNT) ? MAX_COUNT : bus.cfg_count;
          error_d = 1'b0;
          idx_d   = '0;
          state_d = ST_RST_ON;
        end
      end
      // A zero count still passes through here so the MMCM gets one reset pulse
      ST_RST_ON: begin
        idx_d   = '0;
        state_d = (count_q == '0) ? ST_RST_OFF : ST_RD;
      end
      ST_RD: begin
        drdy_tmr_d = '0;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drdy) begin
          do_d    = drp_do;
          state_d = ST_WR;
        end else if (drdy_tmr_q == DTW'(DRDY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_RST_OFF;
        end else begin
          drdy_tmr_d = drdy_tmr_q + 1'b1;
        end
      end
      ST_WR: begin
        drdy_tmr_d = '0;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drdy) begin
          state_d = ST_NEXT;
        end else if (drdy_tmr_q == DTW'(DRDY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_RST_OFF;
        end else begin
          drdy_tmr_d = drdy_tmr_q + 1'b1;
        end
      end
      ST_NEXT: begin
        idx_d   = idx_q + 4'd1;
        state_d = ((idx_q + 4'd1) == count_q) ? ST_RST_OFF : ST_RD;
      end
      ST_RST_OFF: begin
        lock_tmr_d = '0;
        state_d    = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (locked) begin
          done_d  = !error_q;
          state_d = ST_IDLE;
        end else if (lock_tmr_q == LTW'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lock_tmr_d = lock_tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DRP bus drive: address/data/write-enable are zero unless DEN is high
  always_comb begin
    den      = (state_q == ST_RD) || (state_q == ST_WR);
    dwe      = (state_q == ST_WR);
    mmcm_rst = (state_q == ST_RST_ON)  || (state_q == ST_RD) ||
               (state_q == ST_RD_WAIT) || (state_q == ST_WR) ||
               (state_q == ST_WR_WAIT) || (state_q == ST_NEXT);
    pll_out          = '0;
    pll_out[RST_BIT] = mmcm_rst;
    if (den) begin
      pll_out[DADDR_MSB:DADDR_LSB] = cur_entry.addr;
      pll_out[DEN_BIT]             = 1'b1;
      pll_out[DWE_BIT]             = dwe;
      if (dwe) begin
        pll_out[DI_MSB:DI_LSB] = merge_bits(do_q, cur_entry.mask, cur_entry.data);
      end
    end
  end

  assign bus.reconfig_to_pll = pll_out | (64'(clk) << DCLK_BIT);
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = done_q;
  assign bus.error           = error_q;

endmodule

// File: tb/tb_pll_reconfig_drp.sv
// Self-checking bench for pll_reconfig_drp with a behavioural DRP/MMCM model.
module tb_pll_reconfig_drp;
  import pll_reconfig_pkg::*;

  localparam int unsigned NREG = 8;
  localparam int unsigned DTO  = 255;
  localparam int unsigned LTO  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_reconfig_drp_if bus_if();

  pll_reconfig_drp #(
    .NUM_REGS     (NREG),
    .DRDY_TIMEOUT (DTO),
    .LOCK_TIMEOUT (LTO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } txn_t;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] do_init;
    logic [15:0] exp_di;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        seen_q[$];
  txn_t        exp_q[$];
  entry_t      tb_tbl [NREG];
  logic [15:0] drp_mem [128];

  int          drp_lat  = 2;
  bit          drp_dead = 1'b0;
  int          pend     = 0;
  logic [15:0] pend_do  = '0;
  bit          lock_ok  = 1'b1;
  int          lock_cnt = 1000;
  int          adj_viol = 0, idle_viol = 0, rst_viol = 0;
  int          rst_pulses = 0, done_cnt = 0;
  logic        prev_den = 1'b0, prev_rst = 1'b0;
  logic        drdy_r = 1'b0, locked_r = 1'b1;
  logic [15:0] do_r = '0;

  assign bus_if.reconfig_from_pll = {46'b0, locked_r, drdy_r, do_r};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, then run the DRP/MMCM model and monitor
  task automatic tick();
    logic [63:0] t;
    @(negedge clk);
    t      = bus_if.reconfig_to_pll;
    drdy_r = 1'b0;
    do_r   = 16'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drdy_r = 1'b1;
        do_r   = pend_do;
      end
    end
    if (t[23]) begin
      seen_q.push_back('{we: t[24], addr: t[22:16], di: t[15:0]});
      if (prev_den) adj_viol++;
      if (!t[25]) rst_viol++;
      if (t[24]) begin
        drp_mem[t[22:16]] = t[15:0];
        pend_do = 16'h0;
      end else begin
        pend_do = drp_mem[t[22:16]];
      end
      if (!drp_dead) pend = drp_lat;
    end else if (t[24] || (t[22:0] != 23'd0)) begin
      idle_viol++;
    end
    if (t[25] && !prev_rst) rst_pulses++;
    if (t[25]) lock_cnt = 0;
    else if (lock_cnt < 1000) lock_cnt++;
    locked_r = lock_ok && (lock_cnt >= 3);
    if (bus_if.done === 1'b1) done_cnt++;
    prev_den = t[23];
    prev_rst = t[25];
  endtask

  task automatic wr_entry(input int idx, input logic [6:0] a, input logic [15:0] m,
                          input logic [15:0] d);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_idx  = 3'(idx);
    bus_if.cfg_addr = a;
    bus_if.cfg_mask = m;
    bus_if.cfg_data = d;
    tb_tbl[idx]     = '{addr: a, mask: m, data: d};
    tick();
    bus_if.cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] c);
    bus_if.cfg_count = c;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (bus_if.busy === 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({name, " finish"}, 64'(bus_if.busy), 64'd0);
  endtask

  // Reference: sequential read-modify-write over a snapshot of the device registers
  task automatic build_exp(input int cnt);
    logic [15:0] m [128];
    logic [15:0] nv;
    int          n;
    m = drp_mem;
    n = (cnt > int'(NREG)) ? int'(NREG) : cnt;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{we: 1'b0, addr: tb_tbl[i].addr, di: 16'h0});
      nv = (m[tb_tbl[i].addr] & tb_tbl[i].mask) | (tb_tbl[i].data & ~tb_tbl[i].mask);
      m[tb_tbl[i].addr] = nv;
      exp_q.push_back('{we: 1'b1, addr: tb_tbl[i].addr, di: nv});
    end
  endtask

  task automatic cmp_txns(input string name);
    int n;
    chk({name, " txn count"}, 64'(seen_q.size()), 64'(exp_q.size()));
    n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s txn%0d", name, i),
          {40'b0, seen_q[i].we, seen_q[i].addr, seen_q[i].di},
          {40'b0, exp_q[i].we, exp_q[i].addr, exp_q[i].di});
    end
  endtask

  task automatic run_ref(input string name, input logic [3:0] c, input bit with_we);
    seen_q.delete();
    done_cnt = 0;
    if (with_we) begin
      bus_if.cfg_we   = 1'b1;
      bus_if.cfg_idx  = 3'd0;
      bus_if.cfg_addr = 7'($urandom_range(0, 15));
      bus_if.cfg_mask = 16'($urandom);
      bus_if.cfg_data = 16'($urandom);
      tb_tbl[0] = '{addr: bus_if.cfg_addr, mask: bus_if.cfg_mask, data: bus_if.cfg_data};
    end
    build_exp(int'(c));
    do_start(c);
    bus_if.cfg_we = 1'b0;
    wait_idle(name, 3000);
    chk({name, " done"}, 64'(done_cnt), 64'd1);
    chk({name, " error"}, 64'(bus_if.error), 64'd0);
    cmp_txns(name);
  endtask

  vec_t vecs [5];

  initial begin
    int n;
    int cnt0;
    logic [6:0]  a3 [6];
    logic        w3 [6];

    vecs[0] = '{addr: 7'h08, mask: 16'hF000, data: 16'h0145, do_init: 16'hA3C2, exp_di: 16'hA145};
    vecs[1] = '{addr: 7'h10, mask: 16'h0000, data: 16'h1234, do_init: 16'hFFFF, exp_di: 16'h1234};
    vecs[2] = '{addr: 7'h7F, mask: 16'hFFFF, data: 16'h1234, do_init: 16'hBEEF, exp_di: 16'hBEEF};
    vecs[3] = '{addr: 7'h00, mask: 16'h00FF, data: 16'hAB00, do_init: 16'h12CD, exp_di: 16'hABCD};
    vecs[4] = '{addr: 7'h4E, mask: 16'hAAAA, data: 16'hFFFF, do_init: 16'h0000, exp_di: 16'h5555};
    a3 = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h14, 7'h14};
    w3 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 128; i++) drp_mem[i] = 16'($urandom);
    for (int i = 0; i < int'(NREG); i++) tb_tbl[i] = '0;
    bus_if.cfg_we = 1'b0; bus_if.cfg_idx = '0; bus_if.cfg_addr = '0;
    bus_if.cfg_mask = '0; bus_if.cfg_data = '0; bus_if.cfg_count = '0;
    bus_if.start = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset busy",  64'(bus_if.busy), 64'd0);
    chk("reset done",  64'(bus_if.done), 64'd0);
    chk("reset error", 64'(bus_if.error), 64'd0);
    chk("reset bus",   64'(bus_if.reconfig_to_pll[25:0]), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single-entry read-modify-write vectors
    for (int v = 0; v < 5; v++) begin
      wr_entry(0, vecs[v].addr, vecs[v].mask, vecs[v].data);
      drp_mem[vecs[v].addr] = vecs[v].do_init;
      seen_q.delete();
      done_cnt = 0;
      do_start(4'd1);
      wait_idle($sformatf("vec%0d", v), 2000);
      chk($sformatf("vec%0d txns", v), 64'(seen_q.size()), 64'd2);
      if (seen_q.size() >= 2) begin
        chk($sformatf("vec%0d rd", v), {40'b0, seen_q[0].we, seen_q[0].addr, seen_q[0].di},
            {40'b0, 1'b0, vecs[v].addr, 16'h0});
        chk($sformatf("vec%0d wr", v), {40'b0, seen_q[1].we, seen_q[1].addr, seen_q[1].di},
            {40'b0, 1'b1, vecs[v].addr, vecs[v].exp_di});
      end
      chk($sformatf("vec%0d done", v), 64'(done_cnt), 64'd1);
    end

    // Three entries: DRP access order
    wr_entry(0, 7'h08, 16'hFF00, 16'h0011);
    wr_entry(1, 7'h09, 16'h0F0F, 16'h2020);
    wr_entry(2, 7'h14, 16'h0000, 16'h3333);
    seen_q.delete();
    done_cnt = 0;
    do_start(4'd3);
    wait_idle("three", 2000);
    chk("three txns", 64'(seen_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
      chk($sformatf("three order%0d", i), {56'b0, seen_q[i].we, seen_q[i].addr},
          {56'b0, w3[i], a3[i]});
    end
    chk("three done", 64'(done_cnt), 64'd1);

    // DRDY never arrives
    drp_dead = 1'b1;
    wr_entry(0, 7'h08, 16'hF000, 16'h0145);
    seen_q.delete();
    done_cnt = 0;
    do_start(4'd1);
    n = 0;
    while (seen_q.size() == 0 && n < 50) begin tick(); n++; end
    chk("drdy_to den seen", 64'(seen_q.size()), 64'd1);
    n = 0;
    while (bus_if.error !== 1'b1 && n < 400) begin tick(); n++; end
    chk("drdy_to cycles", 64'(n), 64'(DTO + 1));
    chk("drdy_to mmcm rst", 64'(bus_if.reconfig_to_pll[25]), 64'd0);
    wait_idle("drdy_to", 100);
    chk("drdy_to no done", 64'(done_cnt), 64'd0);
    chk("drdy_to sticky", 64'(bus_if.error), 64'd1);
    drp_dead = 1'b0;
    done_cnt = 0;
    do_start(4'd1);
    chk("restart clears error", 64'(bus_if.error), 64'd0);
    wait_idle("restart", 2000);
    chk("restart done", 64'(done_cnt), 64'd1);

    // LOCKED held low
    lock_ok = 1'b0;
    done_cnt = 0;
    do_start(4'd1);
    n = 0;
    while (bus_if.reconfig_to_pll[25] === 1'b1 && n < 200) begin tick(); n++; end
    chk("lock_to rst released", 64'(bus_if.reconfig_to_pll[25]), 64'd0);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 1000) begin tick(); n++; end
    chk("lock_to cycles", 64'(n), 64'(LTO + 1));
    chk("lock_to error", 64'(bus_if.error), 64'd1);
    chk("lock_to no done", 64'(done_cnt), 64'd0);
    lock_ok = 1'b1;

    // Reset in WR_WAIT
    drp_lat = 10;
    wr_entry(0, 7'h08, 16'hF000, 16'h0145);
    seen_q.delete();
    do_start(4'd1);
    n = 0;
    while (seen_q.size() < 2 && n < 100) begin tick(); n++; end
    chk("abort reached write", 64'(seen_q.size()), 64'd2);
    tick();
    rst = 1'b1;
    for (int i = 0; i < int'(NREG); i++) tb_tbl[i] = '0;
    tick();
    chk("abort busy", 64'(bus_if.busy), 64'd0);
    chk("abort mmcm rst", 64'(bus_if.reconfig_to_pll[25]), 64'd0);
    chk("abort den", 64'(bus_if.reconfig_to_pll[23]), 64'd0);
    rst = 1'b0;
    repeat (15) tick();
    chk("abort stray drdy ignored", 64'(bus_if.busy), 64'd0);
    drp_lat = 2;
    run_ref("after abort", 4'd1, 1'b0);

    // Zero count, plus a start while busy
    seen_q.delete();
    done_cnt = 0;
    cnt0 = rst_pulses;
    do_start(4'd0);
    bus_if.cfg_count = 4'd3;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    wait_idle("count0", 100);
    repeat (10) tick();
    chk("count0 no den", 64'(seen_q.size()), 64'd0);
    chk("count0 rst pulses", 64'(rst_pulses - cnt0), 64'd1);
    chk("count0 done", 64'(done_cnt), 64'd1);
    chk("busy start ignored", 64'(bus_if.busy), 64'd0);

    // Randomized tables, counts (including above NUM_REGS) and DRP latency
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++) begin
        wr_entry($urandom_range(0, NREG - 1), 7'($urandom_range(0, 15)),
                 16'($urandom), 16'($urandom));
      end
      drp_lat = $urandom_range(1, 6);
      run_ref($sformatf("rand%0d", it), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    end

    chk("den adjacent", 64'(adj_viol), 64'd0);
    chk("bus idle nonzero", 64'(idle_viol), 64'd0);
    chk("den without mmcm rst", 64'(rst_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconfig_drp.md
PLL_RECONFIG_DRP -- requirements
Module: pll_reconfig_drp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: table depth (entries 0..NUM_REGS-1).
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 255: max clk cycles from DEN to DRDY.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: max clk cycles from reset release to locked.
REQ-004 clk  in  1  sole clock for all logic; also drives DRP DCLK.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  write one table entry; ignored while busy.
REQ-007 cfg_idx  in  3  entry index.
REQ-008 cfg_addr  in  7  DRP address.
REQ-009 cfg_mask  in  16  bit=1 keeps the current register bit.
REQ-010 cfg_data  in  16  new bits, used where mask=0.
REQ-011 cfg_count  in  4  entries to apply (0..NUM_REGS), sampled at start.
REQ-012 start  in  1  one-cycle request; ignored while busy.
REQ-013 busy  out  1  sequence in progress.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 error  out  1  sticky; set on timeout, cleared by the next accepted start.
REQ-016 reconfig_to_pll  out  64  [15:0] DI, [22:16] DADDR, [23] DEN, [24] DWE, [25] MMCM reset, [26] DCLK=clk, [63:27]=0.
REQ-017 reconfig_from_pll  in  64  [15:0] DO, [16] DRDY, [17] LOCKED; other bits ignored.

Function
REQ-018 States: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_OFF, LOCK_WAIT.
REQ-019 IDLE + start: latch cfg_count, clear error, busy=1, go to RST_ON; if cfg_count=0, go straight to RST_OFF (reset pulse only).
REQ-020 RST_ON: drive bit 25 high, hold it high through NEXT, go to RD with idx=0.
REQ-021 RD: one-cycle DEN=1, DWE=0, DADDR=table[idx].addr; go to RD_WAIT.
REQ-022 RD_WAIT: on DRDY, capture DO; go to WR.
REQ-023 WR: one-cycle DEN=1, DWE=1, same DADDR, DI=(DO & mask) | (data & ~mask); go to WR_WAIT.
REQ-024 WR_WAIT: on DRDY, go to NEXT.
REQ-025 NEXT: idx+1; if idx+1 = latched count, go to RST_OFF, else go to RD.
REQ-026 RST_OFF: drive bit 25 low, clear lock timer, go to LOCK_WAIT.
REQ-027 LOCK_WAIT: on LOCKED=1, pulse done, set busy=0, go to IDLE.
REQ-028 DEN SHALL never be high two consecutive cycles; DI, DADDR and DWE SHALL be 0 whenever DEN=0.
REQ-029 DRDY outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-030 A DRDY timer SHALL count cycles in RD_WAIT/WR_WAIT. Reaching DRDY_TIMEOUT: set error, go to RST_OFF, then LOCK_WAIT. done SHALL pulse only if no error occurred.
REQ-031 A lock timer SHALL count cycles in LOCK_WAIT. Reaching LOCK_TIMEOUT: set error, no done, busy=0, go to IDLE.
REQ-032 cfg_we and start in the same cycle in IDLE: the write SHALL take effect first, so the sequence uses the new entry.
REQ-033 A cfg_count above NUM_REGS SHALL be clamped to NUM_REGS.

Reset
REQ-034 On rst: state=IDLE, busy=0, done=0, error=0, reconfig_to_pll[25:0]=0, timers and idx=0, table entries=0.
REQ-035 rst asserted mid-sequence SHALL abort at once and return to IDLE; the MMCM reset bit SHALL drop to 0 with it.

Structure
REQ-036 State enum, bus bit positions (DI/DADDR/DEN/DWE/RST/DCLK, DO/DRDY/LOCKED) and the entry record (addr, mask, data) SHALL live in shared package pll_reconfig_pkg.
REQ-037 The table SHALL be the sub-module pll_reconfig_table (NUM_REGS x 39-bit register file, one write port, one async read port).
REQ-038 All other logic (FSM, timers) SHALL be in pll_reconfig_drp.

Verification
REQ-039 Entry 0 = {addr 0x08, mask 0xF000, data 0x0145}, count=1, DRP model DO=0xA3C2, DRDY after 2 cycles -> write DI=0xA145, bit 25 high throughout, done pulse once LOCKED.
REQ-040 Three entries (addr 0x08, 0x09, 0x14) -> DRP order RD08, WR08, RD09, WR09, RD14, WR14; DEN never high on adjacent cycles.
REQ-041 DRP model never asserts DRDY -> error=1 after 255 cycles, bit 25 released, no done; next start clears error.
REQ-042 LOCKED held low -> error=1 and busy=0 after LOCK_TIMEOUT cycles in LOCK_WAIT, no done.
REQ-043 rst asserted in WR_WAIT -> next cycle busy=0, bit 25=0, DEN=0; a later start runs normally.
REQ-044 cfg_count=0 -> no DEN pulses, one bit-25 pulse, done after LOCKED; start while busy -> ignored.
